bcd_scan_driver: RTL and testbench

BCD_SCAN_DRIVER -- requirements
Module: bcd_scan_driver

---
 rtl/bcd_scan_pkg.sv | 27 ++
 rtl/bcd_decade_cell.sv | 38 +++
 rtl/bcd_scan_driver.sv | 170 +++++++++++++++++
 tb/tb_bcd_scan_driver.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_scan_pkg.sv
// ---------------------------------------------------------------------------
// bcd_scan_pkg
// Shared definitions for the four-digit BCD counter and its multiplexed
// 7-segment scan driver.
//   DIGITS        : number of BCD decades / display digits
//   BCD_BLANK     : code driven on bcd_out for a blanked digit slot
//   bcd_count_t   : packed 4 x 4-bit count, element 0 is the units decade
//   anode_pattern : active-low one-hot anode select for a digit index
// ---------------------------------------------------------------------------
package bcd_scan_pkg;

   localparam int DIGITS = 4;

   localparam logic [3:0] BCD_BLANK = 4'hF;

   typedef logic [DIGITS-1:0][3:0] bcd_count_t;

   // The anodes are active-low, so the selected digit is the single zero
   // bit in the pattern; index 0 drives the units digit (4'b1110).
   function automatic logic [DIGITS-1:0] anode_pattern(input logic [1:0] index);
      logic [DIGITS-1:0] one_hot;
      one_hot        = '0;
      one_hot[index] = 1'b1;
      return ~one_hot;
   endfunction

endpackage

// File: rtl/bcd_decade_cell.sv
// ---------------------------------------------------------------------------
// bcd_decade_cell
// One BCD decade of the display counter. Decades are chained by carry so
// a single increment ripples through in the same clock cycle.
//   clk   : rising-edge system clock
//   rst_n : asynchronous active-low reset, clears the decade
//   clr   : synchronous clear, wins over en
//   en    : carry-in, advances the decade by one on the next edge
//   value : current decade value, always within 0..9
//   carry : carry-out, high when en is high and the decade is about to
//           wrap from 9 to 0
// ---------------------------------------------------------------------------
module bcd_decade_cell (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       clr,
   input  logic       en,
   output logic [3:0] value,
   output logic       carry
);

   // Carry-out is combinational so the next decade sees it in the same cycle
   // and the whole count updates on one edge (0199 -> 0200).
   assign carry = en && (value == 4'd9);

   // Decade register: wraps 9 -> 0 on an enabled step, so it can never leave
   // the 0..9 range. Clear takes priority over any pending carry-in.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         value <= 4'd0;
      end else if (clr) begin
         value <= 4'd0;
      end else if (en) begin
         value <= (value == 4'd9) ? 4'd0 : value + 4'd1;
      end
   end

endmodule

// File: rtl/bcd_scan_driver.sv
// ---------------------------------------------------------------------------
// bcd_scan_driver
// Four-decade BCD event counter (0000..9999) with a time-multiplexed
// 7-segment scan output.
//   SCAN_DIV : clk cycles spent on each digit slot (2..2^20)
//   clk      : rising-edge system clock
//   rst_n    : asynchronous active-low reset
//   inc      : count request level; one increment per 0->1 transition
//   clr      : synchronous clear of the count (highest priority)
//   hold     : freezes the count, edges seen while high are dropped
//   bcd_out  : BCD digit for the currently selected slot
//   an_out   : active-low anode select, bit 0 is the units digit
//   ovf      : one-cycle pulse when the count wraps 9999 -> 0000
// Build option:
//   BCD_SCAN_BLANK_LEADING_ZERO_EN - when defined, zero digits above the
//   units digit with only zeros above them are blanked (bcd_out = 4'hF,
//   an_out = 4'b1111 for that slot).
// ---------------------------------------------------------------------------
module bcd_scan_driver
   import bcd_scan_pkg::*;
#(
   parameter int SCAN_DIV = 50000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       inc,
   input  logic       clr,
   input  logic       hold,
   output logic [3:0] bcd_out,
   output logic [3:0] an_out,
   output logic       ovf
);

   localparam int               PRE_W    = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(SCAN_DIV - 1);

   logic             inc_q;
   logic             edge_armed;
   logic             inc_edge;
   logic             count_en;

   logic [3:0]       digit0;
   logic [3:0]       digit1;
   logic [3:0]       digit2;
   logic [3:0]       digit3;
   logic             carry0;
   logic             carry1;
   logic             carry2;
   logic             carry3;
   bcd_count_t       count;

   logic [PRE_W-1:0] prescale;
   logic [1:0]       index;

   logic             blank_slot;
   logic [3:0]       next_bcd;
   logic [3:0]       next_an;

   // Registered copy of inc for rising-edge detection. edge_armed stays low
   // for the first cycle after reset so that an inc already high at release
   // is not taken as a fresh edge; inc has to fall and rise again first.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         inc_q      <= 1'b0;
         edge_armed <= 1'b0;
      end else begin
         inc_q      <= inc;
         edge_armed <= 1'b1;
      end
   end

   // Clear beats hold beats increment. Gating the increment with clr keeps
   // the carry chain (and therefore ovf) quiet on a clearing cycle.
   assign inc_edge = inc & ~inc_q & edge_armed;
   assign count_en = inc_edge & ~hold & ~clr;

   bcd_decade_cell u_decade0 (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .en    (count_en),
      .value (digit0),
      .carry (carry0)
   );

   bcd_decade_cell u_decade1 (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .en    (carry0),
      .value (digit1),
      .carry (carry1)
   );

   bcd_decade_cell u_decade2 (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .en    (carry1),
      .value (digit2),
      .carry (carry2)
   );

   bcd_decade_cell u_decade3 (
      .clk   (clk),
      .rst_n (rst_n),
      .clr   (clr),
      .en    (carry2),
      .value (digit3),
      .carry (carry3)
   );

   assign count = {digit3, digit2, digit1, digit0};

   // The carry out of the top decade is exactly the 9999 -> 0000 wrap.
   // Registering it lines the pulse up with the cycle the count reads 0000.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         ovf <= 1'b0;
      end else begin
         ovf <= carry3;
      end
   end

   // Free-running slot prescaler and digit index. Neither clr nor hold
   // touches these, so the display keeps scanning while the count is frozen.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescale <= '0;
         index    <= 2'd0;
      end else if (prescale == PRE_LAST) begin
         prescale <= '0;
         index    <= index + 2'd1;
      end else begin
         prescale <= prescale + 1'b1;
      end
   end

   // Select the digit and anode for the current slot. With leading-zero
   // blanking enabled, a slot above the units digit is blanked when its own
   // decade and every decade above it are zero.
   always_comb begin
      blank_slot = 1'b0;
`ifdef BCD_SCAN_BLANK_LEADING_ZERO_EN
      blank_slot = (index != 2'd0);
      for (int d = 0; d < DIGITS; d++) begin
         if ((d >= int'(index)) && (count[d] != 4'd0)) begin
            blank_slot = 1'b0;
         end
      end
`else
      blank_slot = 1'b0;
`endif
      next_bcd = blank_slot ? BCD_BLANK : count[index];
      next_an  = blank_slot ? 4'b1111 : anode_pattern(index);
   end

   // Output registers keep the display lines glitch-free; they trail the
   // index and count registers by one cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         bcd_out <= 4'h0;
         an_out  <= 4'b1110;
      end else begin
         bcd_out <= next_bcd;
         an_out  <= next_an;
      end
   end

endmodule

// File: tb/tb_bcd_scan_driver.sv
// ---------------------------------------------------------------------------
// tb_bcd_scan_driver
// Self-checking bench for bcd_scan_driver with SCAN_DIV = 4. A reference
// model tracks the count as a plain integer and derives the displayed slot
// from the number of clocks since reset; it pushes the expected outputs for
// every clock into a queue, and a monitor pops and compares on the
// following falling edge. Directed sequences plus a randomized phase drive
// the inputs. Defining BCD_SCAN_BLANK_LEADING_ZERO_EN applies to both the
// design and the model.
// ---------------------------------------------------------------------------
module tb_bcd_scan_driver;

   localparam int SCAN_DIV = 4;

   typedef struct {
      logic [3:0] an;
      logic [3:0] bcd;
      logic       ovf;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       inc;
   logic       clr;
   logic       hold;
   logic [3:0] bcd_out;
   logic [3:0] an_out;
   logic       ovf;

   int         n_total;
   int         n_bad;
   exp_t       exp_q[$];
   int         pow10 [4] = '{1, 10, 100, 1000};

   int         m_count;
   bit         m_prev_inc;
   bit         m_armed;
   int         m_cyc;

   bcd_scan_driver #(.SCAN_DIV(SCAN_DIV)) dut (
      .clk     (clk),
      .rst_n   (rst_n),
      .inc     (inc),
      .clr     (clr),
      .hold    (hold),
      .bcd_out (bcd_out),
      .an_out  (an_out),
      .ovf     (ovf)
   );

   // Free-running 10-time-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point: counts every check and reports mismatches.
   task automatic checkOutput(input string name, input logic [15:0] act, input logic [15:0] exp);
      n_total++;
      if (act !== exp) begin
         n_bad++;
         $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Drive one cycle of inputs on the falling edge, away from the DUT's
   // sampling edge.
   task automatic applyStimulus(input logic i, input logic c, input logic h);
      @(negedge clk);
      inc  = i;
      clr  = c;
      hold = h;
   endtask

   task automatic pulseInc();
      applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
   endtask

   task automatic presetCount(input int n);
      applyStimulus(1'b0, 1'b1, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < n; i++) pulseInc();
   endtask

   // Waits a bounded number of cycles for a given anode pattern; running out
   // of budget counts as a failed comparison.
   task automatic waitForAnode(input logic [3:0] pattern, input int budget);
      bit found;
      found = 1'b0;
      for (int i = 0; i < budget && !found; i++) begin
         @(negedge clk);
         if (an_out === pattern) found = 1'b1;
      end
      if (!found) begin
         n_total++;
         n_bad++;
         $display("[TB] FAIL wait_anode: got %0h expected %0h within %0d cycles", an_out, pattern, budget);
      end
   endtask

   // Reference model: count as an integer 0..9999, the slot on display is
   // (clocks since reset / SCAN_DIV) mod 4, and outputs show the state from
   // before the current clock edge.
   initial begin : ref_model
      exp_t e;
      int   slot;
      bit   edge_seen;
      bit   wrap;
      forever begin
         @(posedge clk or negedge rst_n);
         if (!rst_n) begin
            m_count    = 0;
            m_prev_inc = 1'b0;
            m_armed    = 1'b0;
            m_cyc      = 0;
            exp_q.delete();
         end else begin
            slot  = (m_cyc / SCAN_DIV) % 4;
            e.an  = ~(4'b0001 << slot);
            e.bcd = 4'((m_count / pow10[slot]) % 10);
`ifdef BCD_SCAN_BLANK_LEADING_ZERO_EN
            if (slot > 0 && m_count < pow10[slot]) begin
               e.an  = 4'b1111;
               e.bcd = 4'hF;
            end
`endif
            edge_seen = inc && !m_prev_inc && m_armed;
            wrap      = 1'b0;
            if (clr) begin
               m_count = 0;
            end else if (!hold && edge_seen) begin
               if (m_count == 9999) begin
                  m_count = 0;
                  wrap    = 1'b1;
               end else begin
                  m_count = m_count + 1;
               end
            end
            e.ovf = wrap;
            exp_q.push_back(e);
            m_prev_inc = inc;
            m_armed    = 1'b1;
            m_cyc      = m_cyc + 1;
         end
      end
   end

   // Monitor: every clock out of reset presents a new output word, compared
   // against the oldest expected entry.
   initial begin : monitor
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n === 1'b1 && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            checkOutput("an_out", 16'(an_out), 16'(e.an));
            checkOutput("bcd_out", 16'(bcd_out), 16'(e.bcd));
            checkOutput("ovf", 16'(ovf), 16'(e.ovf));
         end
      end
   end

   // Hard stop in case a wait somewhere never returns.
   initial begin : watchdog
      #2000000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", n_total, n_bad + 1);
      $fatal(1, "[TB] watchdog expired");
   end

   // Directed sequences followed by randomized traffic.
   initial begin : stimulus
      int ovf_hits;
      n_total = 0;
      n_bad   = 0;
      rst_n   = 1'b0;
      inc     = 1'b0;
      clr     = 1'b0;
      hold    = 1'b0;

      repeat (2) @(negedge clk);
      checkOutput("reset_an", 16'(an_out), 16'h000E);
      checkOutput("reset_bcd", 16'(bcd_out), 16'h0000);
      checkOutput("reset_ovf", 16'(ovf), 16'h0000);

      @(negedge clk);
      rst_n = 1'b1;
      repeat (20) applyStimulus(1'b0, 1'b0, 1'b0);

      $display("[TB] carry ripple 0199 -> 0200");
      presetCount(199);
      pulseInc();
      repeat (2) @(negedge clk);
      waitForAnode(4'b1011, 20);
      checkOutput("slot2_after_carry", 16'(bcd_out), 16'h0002);

      $display("[TB] wrap 9999 -> 0000");
      presetCount(9999);
      repeat (4) applyStimulus(1'b0, 1'b0, 1'b0);
      ovf_hits = 0;
      applyStimulus(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         @(negedge clk);
         inc = 1'b0;
         if (ovf === 1'b1) ovf_hits++;
      end
      checkOutput("ovf_pulse_count", 16'(ovf_hits), 16'd1);
      repeat (16) applyStimulus(1'b0, 1'b0, 1'b0);

      $display("[TB] long inc level, hold with edges, clr with inc");
      repeat (10) applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 5; i++) begin
         applyStimulus(1'b1, 1'b0, 1'b1);
         applyStimulus(1'b0, 1'b0, 1'b1);
      end
      repeat (16) applyStimulus(1'b0, 1'b0, 1'b0);
      presetCount(5);
      applyStimulus(1'b1, 1'b1, 1'b0);
      repeat (16) applyStimulus(1'b0, 1'b0, 1'b0);

      $display("[TB] inc high across reset release");
      applyStimulus(1'b1, 1'b0, 1'b0);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (10) applyStimulus(1'b1, 1'b0, 1'b0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      pulseInc();
      repeat (16) applyStimulus(1'b0, 1'b0, 1'b0);

      $display("[TB] randomized traffic");
      for (int i = 0; i < 3000; i++) begin
         applyStimulus(1'($urandom_range(0, 1)),
                       1'($urandom_range(0, 39) == 0),
                       1'($urandom_range(0, 7) == 0));
      end
      repeat (16) applyStimulus(1'b0, 1'b0, 1'b0);

`ifdef BCD_SCAN_BLANK_LEADING_ZERO_EN
      $display("[TB] leading zero blanking at 0007");
      presetCount(7);
      repeat (20) applyStimulus(1'b0, 1'b0, 1'b0);
`endif

      $display("[TB] asynchronous reset mid-slot at 0345");
      presetCount(345);
      repeat (2) @(negedge clk);
      waitForAnode(4'b1011, 40);
      @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_an", 16'(an_out), 16'h000E);
      checkOutput("async_rst_bcd", 16'(bcd_out), 16'h0000);
      checkOutput("async_rst_ovf", 16'(ovf), 16'h0000);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      repeat (20) applyStimulus(1'b0, 1'b0, 1'b0);

      repeat (2) @(negedge clk);
      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
